// File: rtl/deser_pkg.sv
// Shared types and helpers for the multi-lane serial-to-parallel stream converter.
package deser_pkg;

  typedef enum logic {
    ORDER_MSB_FIRST = 1'b0,
    ORDER_LSB_FIRST = 1'b1
  } order_e;

  // Number of enabled beats needed to fill one output word.
  function automatic int beats_f(input int width, input int lanes);
    return width / lanes;
  endfunction

endpackage

// File: rtl/deserializer_stream_sync_fifo.sv
// Small synchronous FIFO with a show-ahead head word. A push into a full FIFO
// is still accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wrPtr;
  logic [ADDR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic              w_doPush;
  logic              w_doPop;

  // Qualify push/pop against occupancy; a pop frees the slot a full push needs.
  always_comb begin
    w_doPop  = i_pop & ~o_empty;
    w_doPush = i_push & (~o_full | w_doPop);
  end

  // Storage array: written only, never reset, since the head is masked when empty.
  always_ff @(posedge i_clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rdPtr];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/deserializer_stream.sv
// Multi-lane serial-to-parallel converter: assembles LANES bits per enabled beat
// into DATA_WIDTH-bit words and hands them to a small output FIFO.
module deserializer_stream
  import deser_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 1,
  parameter int OUT_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LANES-1:0]      serial_in,
  input  logic                  enable,
  input  logic                  start,
  input  logic                  msb_first,
  input  logic                  continuous,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  drop
);

  localparam int BEATS = beats_f(DATA_WIDTH, LANES);
  localparam int CNT_W = $clog2(BEATS) + 1;

  if (DATA_WIDTH % LANES != 0) begin : g_badWidth
    $error("DATA_WIDTH must be a multiple of LANES");
  end
  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_badLanes
    $error("LANES must be 1, 2, 4 or 8");
  end
  if (OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : g_badDepth
    $error("OUT_DEPTH must be a power of two and at least 2");
  end

  logic                  r_busy;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  order_e                r_order;
  logic                  r_cont;
  logic                  r_drop;

  order_e                w_order;
  logic                  w_cont;
  logic                  w_capture;
  logic [CNT_W-1:0]      w_beatIdx;
  logic [CNT_W-1:0]      w_nextCnt;
  logic [DATA_WIDTH-1:0] w_base;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_complete;
  logic                  w_pop;
  logic                  w_fifoFull;
  logic                  w_fifoEmpty;
  logic [DATA_WIDTH-1:0] w_head;

  // Beat assembly: start overrides the latched mode and rewinds to beat 0, and
  // beat 0 always builds on a cleared word so continuous words never mix.
  always_comb begin
    w_order   = r_order;
    w_cont    = r_cont;
    w_beatIdx = r_cnt;
    if (start) begin
      w_order   = msb_first ? ORDER_MSB_FIRST : ORDER_LSB_FIRST;
      w_cont    = continuous;
      w_beatIdx = '0;
    end
    w_base     = (w_beatIdx == '0) ? '0 : r_shift;
    w_capture  = enable & (start | r_busy);
    w_nextCnt  = w_beatIdx + 1'b1;
    w_complete = w_capture & (w_nextCnt == CNT_W'(BEATS));
    if (w_order == ORDER_MSB_FIRST) begin
      w_word = (w_base << LANES) | DATA_WIDTH'(serial_in);
    end else begin
      w_word = w_base | (DATA_WIDTH'(serial_in) << (w_beatIdx * LANES));
    end
  end

  // Word-in-progress state: mode latches, beat counter and assembly register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_order <= ORDER_MSB_FIRST;
      r_cont  <= 1'b0;
    end else begin
      if (start) begin
        r_order <= w_order;
        r_cont  <= w_cont;
        r_busy  <= 1'b1;
        r_cnt   <= '0;
      end
      if (w_capture) begin
        r_shift <= w_word;
        if (w_complete) begin
          r_cnt  <= '0;
          r_busy <= w_cont;
        end else begin
          r_cnt  <= w_nextCnt;
        end
      end
    end
  end

  // Drop is registered so it lines up with the cycle the word would have appeared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_complete & w_fifoFull & ~w_pop;
    end
  end

  assign w_pop = ~w_fifoEmpty & out_ready;

  sync_fifo #(
    .WIDTH(DATA_WIDTH),
    .DEPTH(OUT_DEPTH)
  ) u_fifo (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_push (w_complete),
    .i_data (w_word),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_full (w_fifoFull),
    .o_empty(w_fifoEmpty)
  );

  assign out_valid = ~w_fifoEmpty;
  assign out_data  = w_fifoEmpty ? '0 : w_head;
  assign busy      = r_busy;
  assign drop      = r_drop;

endmodule

// File: tb/tb_deserializer_stream.sv
// Bench for deserializer_stream: a queue-based word model checked every cycle
// on the single-lane instance, plus literal expectations on both instances.
module tb_deserializer_stream;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       serialIn;
  logic       enable;
  logic       start;
  logic       msbFirst;
  logic       continuous;
  logic       outReady;
  logic [7:0] outData;
  logic       outValid;
  logic       busy;
  logic       drop;

  logic [1:0] serial2;
  logic       enable2;
  logic       start2;
  logic       msbFirst2;
  logic       continuous2;
  logic       outReady2;
  logic [7:0] outData2;
  logic       outValid2;
  logic       busy2;
  logic       drop2;

  int checkCount = 0;
  int passCount  = 0;
  bit checking   = 1'b0;

  bit         mBusy = 1'b0;
  bit         mMsb  = 1'b1;
  bit         mCont = 1'b0;
  bit         mDrop = 1'b0;
  bit         mBits[$];
  logic [7:0] mFifo[$];

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  deserializer_stream #(.DATA_WIDTH(8), .LANES(1), .OUT_DEPTH(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .serial_in (serialIn),
    .enable    (enable),
    .start     (start),
    .msb_first (msbFirst),
    .continuous(continuous),
    .out_data  (outData),
    .out_valid (outValid),
    .out_ready (outReady),
    .busy      (busy),
    .drop      (drop)
  );

  deserializer_stream #(.DATA_WIDTH(8), .LANES(2), .OUT_DEPTH(2)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .serial_in (serial2),
    .enable    (enable2),
    .start     (start2),
    .msb_first (msbFirst2),
    .continuous(continuous2),
    .out_data  (outData2),
    .out_valid (outValid2),
    .out_ready (outReady2),
    .busy      (busy2),
    .drop      (drop2)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word model: collect sampled bits into a list, turn eight of them into a
  // byte by the latched order, and keep completed bytes in a two-entry queue.
  task automatic modelStep();
    bit         popNow;
    bit         done;
    logic [7:0] w;
    w = '0;
    if (!rst_n) begin
      mBusy = 1'b0;
      mBits.delete();
      mFifo.delete();
      mDrop = 1'b0;
      mMsb  = 1'b1;
      mCont = 1'b0;
    end else begin
      popNow = (mFifo.size() != 0) && outReady;
      done   = 1'b0;
      if (start) begin
        mBusy = 1'b1;
        mBits.delete();
        mMsb  = msbFirst;
        mCont = continuous;
      end
      if (mBusy && enable) begin
        mBits.push_back(serialIn);
        if (mBits.size() == 8) begin
          for (int i = 0; i < 8; i++) begin
            if (mMsb) w = {w[6:0], mBits[i]};
            else      w[i] = mBits[i];
          end
          done = 1'b1;
          mBits.delete();
          mBusy = mCont;
        end
      end
      if (popNow) void'(mFifo.pop_front());
      mDrop = 1'b0;
      if (done) begin
        if (mFifo.size() < 2) mFifo.push_back(w);
        else                  mDrop = 1'b1;
      end
    end
  endtask

  // Advance the model on every rising edge using the inputs the DUT sampled.
  initial begin
    forever begin
      @(posedge clk);
      modelStep();
    end
  end

  // Compare the single-lane instance against the model mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        checkOutput("cmpValid", 32'(outValid), 32'(mFifo.size() != 0));
        checkOutput("cmpData", 32'(outData), (mFifo.size() != 0) ? 32'(mFifo[0]) : 32'd0);
        checkOutput("cmpBusy", 32'(busy), 32'(mBusy));
        checkOutput("cmpDrop", 32'(drop), 32'(mDrop));
      end
    end
  end

  task automatic applyStimulus(input logic st, input logic en, input logic sb,
                               input logic msb, input logic cont, input logic rdy);
    start      = st;
    enable     = en;
    serialIn   = sb;
    msbFirst   = msb;
    continuous = cont;
    outReady   = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus2(input logic st, input logic en, input logic [1:0] s, input logic msb);
    start2      = st;
    enable2     = en;
    serial2     = s;
    msbFirst2   = msb;
    continuous2 = 1'b0;
    outReady2   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Sends stream[7] first; msbPin only drives the order input.
  task automatic sendBits(input logic [7:0] stream, input logic msbPin, input logic contPin,
                          input logic rdy, input logic withStart, input int gapAfter);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(withStart && (i == 0), 1'b1, stream[7-i], msbPin, contPin, rdy);
      if (i == gapAfter) applyStimulus(1'b0, 1'b0, 1'b1, msbPin, contPin, rdy);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rdy);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; enable = 1'b0; serialIn = 1'b0; msbFirst = 1'b1; continuous = 1'b0; outReady = 1'b0;
    start2 = 1'b0; enable2 = 1'b0; serial2 = 2'b00; msbFirst2 = 1'b1; continuous2 = 1'b0; outReady2 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rstValid", 32'(outValid), 32'd0);
    checkOutput("rstData", 32'(outData), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDrop", 32'(drop), 32'd0);
    checkOutput("rstValid2", 32'(outValid2), 32'd0);
    rst_n = 1'b1;
    checking = 1'b1;

    $display("[TB] single lane MSB-first and LSB-first");
    sendBits(8'hB2, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    checkOutput("msbValid", 32'(outValid), 32'd1);
    checkOutput("msbWord", 32'(outData), 32'hB2);
    idle(1, 1'b1);
    sendBits(8'hB2, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    checkOutput("lsbWord", 32'(outData), 32'h4D);
    checkOutput("lsbBusy", 32'(busy), 32'd0);
    idle(1, 1'b1);

    $display("[TB] continuous back-to-back words with enable gaps");
    sendBits(8'hB2, 1'b1, 1'b1, 1'b1, 1'b1, 3);
    checkOutput("contWord1", 32'(outData), 32'hB2);
    sendBits(8'h4D, 1'b0, 1'b0, 1'b1, 1'b0, 5);
    checkOutput("contWord2", 32'(outData), 32'h4D);
    checkOutput("contBusy", 32'(busy), 32'd1);
    checkOutput("contDrop", 32'(drop), 32'd0);
    idle(1, 1'b1);

    $display("[TB] stalled consumer, overflow drop");
    sendBits(8'hA1, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    sendBits(8'h5C, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    sendBits(8'h33, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    checkOutput("ovfDrop", 32'(drop), 32'd1);
    checkOutput("ovfHead", 32'(outData), 32'hA1);
    idle(1, 1'b0);
    checkOutput("ovfDropPulse", 32'(drop), 32'd0);
    idle(1, 1'b1);
    checkOutput("drainSecond", 32'(outData), 32'h5C);
    idle(1, 1'b1);
    checkOutput("drainValid", 32'(outValid), 32'd0);
    checkOutput("drainData", 32'(outData), 32'd0);

    $display("[TB] restart mid-word and start without enable");
    for (int i = 0; i < 5; i++) applyStimulus(i == 0, 1'b1, i[0], 1'b1, 1'b0, 1'b1);
    sendBits(8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    checkOutput("restartWord", 32'(outData), 32'hFF);
    checkOutput("restartDrop", 32'(drop), 32'd0);
    idle(2, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("startNoEnBusy", 32'(busy), 32'd1);
    sendBits(8'h96, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    checkOutput("startNoEnWord", 32'(outData), 32'h96);
    idle(2, 1'b1);

    $display("[TB] reset mid-word with a queued word");
    sendBits(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    for (int i = 0; i < 3; i++) applyStimulus(i == 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("rstMidValid", 32'(outValid), 32'd0);
    checkOutput("rstMidBusy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    sendBits(8'hC3, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    checkOutput("postRstWord", 32'(outData), 32'hC3);
    idle(2, 1'b1);

    $display("[TB] two-lane instance");
    applyStimulus2(1'b1, 1'b1, 2'b10, 1'b1);
    applyStimulus2(1'b0, 1'b1, 2'b11, 1'b1);
    applyStimulus2(1'b0, 1'b1, 2'b00, 1'b1);
    applyStimulus2(1'b0, 1'b1, 2'b01, 1'b1);
    checkOutput("lane2MsbValid", 32'(outValid2), 32'd1);
    checkOutput("lane2MsbWord", 32'(outData2), 32'hB1);
    applyStimulus2(1'b0, 1'b0, 2'b00, 1'b1);
    applyStimulus2(1'b1, 1'b1, 2'b10, 1'b0);
    applyStimulus2(1'b0, 1'b1, 2'b11, 1'b1);
    applyStimulus2(1'b0, 1'b1, 2'b00, 1'b1);
    applyStimulus2(1'b0, 1'b1, 2'b01, 1'b1);
    checkOutput("lane2LsbWord", 32'(outData2), 32'h4E);
    checkOutput("lane2Busy", 32'(busy2), 32'd0);
    checkOutput("lane2Drop", 32'(drop2), 32'd0);
    applyStimulus2(1'b0, 1'b0, 2'b00, 1'b1);
    checkOutput("lane2Empty", 32'(outValid2), 32'd0);

    checking = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
